// File: rtl/ball_pkg.sv
// Shared FSM state type and default lane geometry for the bowling-ball physics block.
package ball_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ROLL   = 2'd1,
    ST_FINISH = 2'd2
  } ball_state_e;

  localparam int unsigned DEF_TICK_DIV = 3000000;
  localparam int unsigned DEF_X_START  = 144;
  localparam int unsigned DEF_Y_START  = 420;
  localparam int unsigned DEF_X_END    = 1024;
  localparam int unsigned DEF_PIN_X    = 624;
  localparam int unsigned DEF_LANE_TOP = 300;
  localparam int unsigned DEF_LANE_BOT = 540;

endpackage

// File: rtl/tick_gen.sv
// Prescaler producing a one-cycle physics tick every DIV enabled cycles.
module tick_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic en,
  input  logic clr,
  output logic tick_c
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  assign tick_c = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/ball_physics.sv
// Fixed-point ball roll along a lane: launch, per-tick motion with friction,
// wall bounce or gutter, and end-of-lane detection.
module ball_physics
  import ball_pkg::*;
#(
  parameter int unsigned X_W      = 11,
  parameter int unsigned Y_W      = 10,
  parameter int unsigned V_W      = 16,
  parameter int unsigned FRAC     = 4,
  parameter int unsigned TICK_DIV = DEF_TICK_DIV,
  parameter int unsigned FRICTION = 0,
  parameter int unsigned MIN_VX   = 1,
  parameter int unsigned X_START  = DEF_X_START,
  parameter int unsigned Y_START  = DEF_Y_START,
  parameter int unsigned X_END    = DEF_X_END,
  parameter int unsigned PIN_X    = DEF_PIN_X,
  parameter int unsigned LANE_TOP = DEF_LANE_TOP,
  parameter int unsigned LANE_BOT = DEF_LANE_BOT
) (
  input  logic           clk_in,
  input  logic           rst_n_in,
  input  logic           launch_valid_in,
  output logic           launch_ready_out,
  input  logic [V_W-1:0] init_vx_in,
  input  logic [V_W-1:0] init_vy_in,
  input  logic           bounce_en_in,
  output logic [X_W-1:0] ball_x_out,
  output logic [Y_W-1:0] ball_y_out,
  output logic [V_W-1:0] vel_x_out,
  output logic [V_W-1:0] vel_y_out,
  output logic           in_pin_zone_out,
  output logic           busy_out,
  output logic           done_out,
  output logic           gutter_out
);

  localparam int unsigned XF_W = X_W + FRAC;
  localparam int unsigned YF_W = Y_W + FRAC;
  // Sum widths leave headroom so a fast ball can never wrap past a limit.
  localparam int unsigned XS_W = ((XF_W > V_W) ? XF_W : V_W) + 1;
  localparam int unsigned YS_W = ((YF_W > V_W) ? YF_W : V_W) + 2;

  localparam logic [XF_W-1:0]        X_START_FX = XF_W'(X_START << FRAC);
  localparam logic [YF_W-1:0]        Y_START_FX = YF_W'(Y_START << FRAC);
  localparam logic [XF_W-1:0]        X_END_FX   = XF_W'(X_END << FRAC);
  localparam logic [XS_W-1:0]        X_END_CMP  = XS_W'(X_END << FRAC);
  localparam logic [XF_W-1:0]        PIN_X_FX   = XF_W'(PIN_X << FRAC);
  localparam logic signed [YS_W-1:0] Y_TOP_FX   = $signed(YS_W'(LANE_TOP << FRAC));
  localparam logic signed [YS_W-1:0] Y_BOT_FX   = $signed(YS_W'(LANE_BOT << FRAC));
  localparam logic [V_W-1:0]         FRICTION_V = V_W'(FRICTION);
  localparam logic [V_W-1:0]         MIN_VX_V   = V_W'(MIN_VX);

  ball_state_e state_q, state_d;
  logic [XF_W-1:0] x_q, x_d;
  logic [YF_W-1:0] y_q, y_d;
  logic [V_W-1:0]  vx_q, vx_d;
  logic [V_W-1:0]  vy_q, vy_d;
  logic            bounce_q, bounce_d;
  logic            gutter_d;

  logic                   accept_c;
  logic                   tick_c;
  logic [XS_W-1:0]        x_sum;
  logic [YS_W-1:0]        vy_ext;
  logic signed [YS_W-1:0] y_sum;
  logic signed [YS_W-1:0] y_clamp;
  logic [V_W-1:0]         vx_fr;
  logic [V_W-1:0]         vx_new;
  logic                   hit_top;
  logic                   hit_bot;
  logic                   x_end;

  assign accept_c = (state_q == ST_IDLE) && launch_valid_in;

  tick_gen #(
    .DIV (TICK_DIV)
  ) u_tick_gen (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .en       (state_q == ST_ROLL),
    .clr      (accept_c),
    .tick_c   (tick_c)
  );

  // Candidate next position/velocity and limit detection.
  always_comb begin
    x_sum   = XS_W'(x_q) + XS_W'(vx_q);
    vy_ext  = {{(YS_W - V_W){vy_q[V_W-1]}}, vy_q};
    y_sum   = $signed(YS_W'(y_q)) + $signed(vy_ext);
    vx_fr   = (vx_q > FRICTION_V) ? vx_q - FRICTION_V : '0;
    vx_new  = (vx_fr < MIN_VX_V) ? MIN_VX_V : vx_fr;
    hit_top = (vy_q != '0) && (y_sum < Y_TOP_FX);
    hit_bot = (vy_q != '0) && (y_sum > Y_BOT_FX);
    x_end   = (x_sum >= X_END_CMP);
    if (hit_top) begin
      y_clamp = Y_TOP_FX;
    end else if (hit_bot) begin
      y_clamp = Y_BOT_FX;
    end else begin
      y_clamp = y_sum;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    vx_d     = vx_q;
    vy_d     = vy_q;
    bounce_d = bounce_q;
    gutter_d = gutter_out;
    case (state_q)
      ST_IDLE: begin
        if (launch_valid_in) begin
          state_d  = ST_ROLL;
          x_d      = X_START_FX;
          y_d      = Y_START_FX;
          vx_d     = init_vx_in;
          vy_d     = init_vy_in;
          bounce_d = bounce_en_in;
          gutter_d = 1'b0;
        end
      end
      ST_ROLL: begin
        if (tick_c) begin
          vx_d = vx_new;
          y_d  = YF_W'(y_clamp);
          if (x_end) begin
            x_d     = X_END_FX;
            state_d = ST_FINISH;
          end else begin
            x_d = XF_W'(x_sum);
            if (hit_top || hit_bot) begin
              if (bounce_q) begin
                vy_d = -vy_q;
              end else begin
                gutter_d = 1'b1;
                state_d  = ST_FINISH;
              end
            end
          end
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q          <= ST_IDLE;
      x_q              <= X_START_FX;
      y_q              <= Y_START_FX;
      vx_q             <= '0;
      vy_q             <= '0;
      bounce_q         <= 1'b0;
      gutter_out       <= 1'b0;
      launch_ready_out <= 1'b1;
      busy_out         <= 1'b0;
      done_out         <= 1'b0;
      in_pin_zone_out  <= 1'b0;
    end else begin
      state_q          <= state_d;
      x_q              <= x_d;
      y_q              <= y_d;
      vx_q             <= vx_d;
      vy_q             <= vy_d;
      bounce_q         <= bounce_d;
      gutter_out       <= gutter_d;
      launch_ready_out <= (state_d == ST_IDLE);
      busy_out         <= (state_d == ST_ROLL);
      done_out         <= (state_d == ST_FINISH);
      in_pin_zone_out  <= (state_d == ST_ROLL) && (x_d >= PIN_X_FX);
    end
  end

  assign ball_x_out = x_q[XF_W-1:FRAC];
  assign ball_y_out = y_q[YF_W-1:FRAC];
  assign vel_x_out  = vx_q;
  assign vel_y_out  = vy_q;

endmodule

// File: tb/tb_ball_physics.sv
// Directed bench for ball_physics with a fast tick (TICK_DIV=4) and a second friction instance.
module tb_ball_physics;

  logic        clk_in;
  logic        rst_n_in;
  logic        valid_a, valid_b;
  logic [15:0] vx_i, vy_i;
  logic        bnc_i;

  logic        ready_a, pin_a, busy_a, done_a, gutter_a;
  logic [10:0] x_a;
  logic [9:0]  y_a;
  logic [15:0] velx_a, vely_a;

  logic        ready_b, pin_b, busy_b, done_b, gutter_b;
  logic [10:0] x_b;
  logic [9:0]  y_b;
  logic [15:0] velx_b, vely_b;

  int checks = 0;
  int errors = 0;

  ball_physics #(.TICK_DIV(4)) dut (
    .clk_in           (clk_in),
    .rst_n_in         (rst_n_in),
    .launch_valid_in  (valid_a),
    .launch_ready_out (ready_a),
    .init_vx_in       (vx_i),
    .init_vy_in       (vy_i),
    .bounce_en_in     (bnc_i),
    .ball_x_out       (x_a),
    .ball_y_out       (y_a),
    .vel_x_out        (velx_a),
    .vel_y_out        (vely_a),
    .in_pin_zone_out  (pin_a),
    .busy_out         (busy_a),
    .done_out         (done_a),
    .gutter_out       (gutter_a)
  );

  ball_physics #(.TICK_DIV(4), .FRICTION(8)) dut_fr (
    .clk_in           (clk_in),
    .rst_n_in         (rst_n_in),
    .launch_valid_in  (valid_b),
    .launch_ready_out (ready_b),
    .init_vx_in       (vx_i),
    .init_vy_in       (vy_i),
    .bounce_en_in     (bnc_i),
    .ball_x_out       (x_b),
    .ball_y_out       (y_b),
    .vel_x_out        (velx_b),
    .vel_y_out        (vely_b),
    .in_pin_zone_out  (pin_b),
    .busy_out         (busy_b),
    .done_out         (done_b),
    .gutter_out       (gutter_b)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (4 * n) @(negedge clk_in);
  endtask

  task automatic launch_a(input logic [15:0] vx, input logic [15:0] vy, input logic b);
    vx_i = vx; vy_i = vy; bnc_i = b; valid_a = 1'b1;
    @(negedge clk_in);
    valid_a = 1'b0;
  endtask

  task automatic abort_run();
    rst_n_in = 1'b0;
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);
  endtask

  initial begin
    logic seen;
    rst_n_in = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
    vx_i = '0; vy_i = '0; bnc_i = 1'b0;
    repeat (3) @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);
    check("rst_ready", 32'(ready_a), 32'd1);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_x", 32'(x_a), 32'd144);
    check("rst_y", 32'(y_a), 32'd420);
    check("rst_vx", 32'(velx_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);

    // Gutter run: straight into the top wall with bounce disabled.
    launch_a(16'h0010, 16'hFF00, 1'b0);
    check("g_busy", 32'(busy_a), 32'd1);
    check("g_ready", 32'(ready_a), 32'd0);
    ticks(1);
    check("g_y_t1", 32'(y_a), 32'd404);
    check("g_x_t1", 32'(x_a), 32'd145);
    ticks(6);
    check("g_y_t7", 32'(y_a), 32'd308);
    ticks(1);
    check("g_y_t8", 32'(y_a), 32'd300);
    check("g_gutter", 32'(gutter_a), 32'd1);
    check("g_done", 32'(done_a), 32'd1);
    check("g_busy_end", 32'(busy_a), 32'd0);
    @(negedge clk_in);
    check("g_done_pulse", 32'(done_a), 32'd0);
    check("g_ready_end", 32'(ready_a), 32'd1);
    check("g_gutter_hold", 32'(gutter_a), 32'd1);

    // Straight run to the lane end, with a valid held mid-roll.
    launch_a(16'h0040, 16'h0000, 1'b0);
    check("s_gutter_clr", 32'(gutter_a), 32'd0);
    repeat (3) @(negedge clk_in);
    check("s_latency", 32'(x_a), 32'd144);
    @(negedge clk_in);
    check("s_x_t1", 32'(x_a), 32'd148);
    ticks(1);
    check("s_x_t2", 32'(x_a), 32'd152);
    valid_a = 1'b1; vx_i = 16'h0100;
    ticks(1);
    valid_a = 1'b0;
    check("s_ign_x", 32'(x_a), 32'd156);
    check("s_ign_vx", 32'(velx_a), 32'h40);
    check("s_ign_busy", 32'(busy_a), 32'd1);
    ticks(116);
    check("s_x_t119", 32'(x_a), 32'd620);
    check("s_pin_off", 32'(pin_a), 32'd0);
    ticks(1);
    check("s_pin_on", 32'(pin_a), 32'd1);
    ticks(99);
    check("s_x_t219", 32'(x_a), 32'd1020);
    check("s_done_early", 32'(done_a), 32'd0);
    ticks(1);
    check("s_x_end", 32'(x_a), 32'd1024);
    check("s_done", 32'(done_a), 32'd1);
    check("s_gutter", 32'(gutter_a), 32'd0);
    @(negedge clk_in);
    check("s_done_pulse", 32'(done_a), 32'd0);
    check("s_ready", 32'(ready_a), 32'd1);
    check("s_x_hold", 32'(x_a), 32'd1024);

    // Bounce run, then reset mid-roll.
    launch_a(16'h0010, 16'hFF00, 1'b1);
    ticks(7);
    check("b_y_t7", 32'(y_a), 32'd308);
    ticks(1);
    check("b_y_t8", 32'(y_a), 32'd300);
    check("b_vy", 32'(vely_a), 32'h0100);
    check("b_busy", 32'(busy_a), 32'd1);
    check("b_gutter", 32'(gutter_a), 32'd0);
    check("b_x_t8", 32'(x_a), 32'd152);
    ticks(1);
    check("b_y_t9", 32'(y_a), 32'd316);
    rst_n_in = 1'b0;
    #1;
    check("r_ready", 32'(ready_a), 32'd1);
    check("r_busy", 32'(busy_a), 32'd0);
    check("r_x", 32'(x_a), 32'd144);
    check("r_y", 32'(y_a), 32'd420);
    check("r_vx", 32'(velx_a), 32'd0);
    check("r_vy", 32'(vely_a), 32'd0);
    check("r_pin", 32'(pin_a), 32'd0);
    @(negedge clk_in);
    check("r_done", 32'(done_a), 32'd0);
    rst_n_in = 1'b1;
    @(negedge clk_in);
    check("r_done_after", 32'(done_a), 32'd0);
    check("r_ready_after", 32'(ready_a), 32'd1);

    // Zero launch speed is lifted to the floor on the first tick.
    launch_a(16'h0000, 16'h0000, 1'b0);
    ticks(1);
    check("z_vx", 32'(velx_a), 32'd1);
    check("z_x_t1", 32'(x_a), 32'd144);
    ticks(16);
    check("z_x_t17", 32'(x_a), 32'd145);
    abort_run();

    // Friction instance decays to the floor and still reaches the end.
    vx_i = 16'h0010; vy_i = 16'h0000; bnc_i = 1'b0; valid_b = 1'b1;
    @(negedge clk_in);
    valid_b = 1'b0;
    ticks(1);
    check("f_vx_t1", 32'(velx_b), 32'h8);
    check("f_x_t1", 32'(x_b), 32'd145);
    ticks(1);
    check("f_vx_t2", 32'(velx_b), 32'h1);
    ticks(5);
    check("f_vx_hold", 32'(velx_b), 32'h1);
    seen = 1'b0;
    for (int i = 0; i < 60000 && !seen; i++) begin
      @(negedge clk_in);
      if (done_b) seen = 1'b1;
    end
    check("f_done_seen", 32'(seen), 32'd1);
    check("f_x_end", 32'(x_b), 32'd1024);
    check("f_gutter", 32'(gutter_b), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
